// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // Scan-code prefixes
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // 1 when data byte plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser chain followed by a hysteresis filter: the output follows the pad only after
// FILT_LEN consecutive synchronised samples disagree with the current filtered value.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic pad,
  output logic filt
);

  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt   = filt_q;

  // Synchroniser chain; idle-high lines reset to 1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

  // Count consecutive disagreeing samples; flip once the run reaches FILT_LEN
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CntW'(FILT_LEN - 1)) filt_d = synced;
      else                              cnt_d  = cnt_q + 1'b1;
    end
  end

  // Filter state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity, stop).
// Bits are taken on filtered falling edges of ps2c; parity, stop bit and an inter-bit
// timeout are checked per frame and reported with single-cycle strobes.
// Build option: define PS2_BREAK_DECODE_EN to fold F0/E0 prefixes into brk/ext qualifiers.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       brk,
  output logic       ext
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic c_filt, d_filt, c_prev_q, fall;

  ps2_state_e      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d, ext_q, ext_d;
  logic            frame_ok;
`ifdef PS2_BREAK_DECODE_EN
  logic            pbrk_q, pbrk_d, pext_q, pext_d;
`endif

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_c (
    .CLK (CLK),
    .RST (RST),
    .pad (ps2c),
    .filt(c_filt)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_d (
    .CLK (CLK),
    .RST (RST),
    .pad (ps2d),
    .filt(d_filt)
  );

  assign fall       = c_prev_q & ~c_filt;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != StIdle);
  assign brk        = brk_q;
  assign ext        = ext_q;

  // Frame FSM, timeout and output next-state
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    brk_d    = 1'b0;
    ext_d    = 1'b0;
    frame_ok = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
    pbrk_d   = pbrk_q;
    pext_d   = pext_q;
`endif

    if (!rx_en) begin
      state_d  = StIdle;
      bitcnt_d = '0;
      tmo_d    = '0;
    end else begin
      if (state_q == StIdle || fall) tmo_d = '0;
      else                           tmo_d = tmo_q + 1'b1;

      if (fall) begin
        unique case (state_q)
          StIdle: begin
            // A high data line at a clock fall is noise, not a start bit
            if (!d_filt) begin
              state_d  = StData;
              bitcnt_d = '0;
            end
          end
          StData: begin
            shift_d[bitcnt_q] = d_filt;
            if (bitcnt_q == 3'd7) state_d  = StParity;
            else                  bitcnt_d = bitcnt_q + 1'b1;
          end
          StParity: begin
            par_d   = d_filt;
            state_d = StStop;
          end
          StStop: begin
            state_d = StIdle;
            if (!d_filt)                             fe_d     = 1'b1;
            else if (!odd_parity_ok(shift_q, par_q)) pe_d     = 1'b1;
            else                                     frame_ok = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        // Fall wins over timeout because this branch is only taken without a fall
        state_d = StIdle;
        fe_d    = 1'b1;
      end
    end

`ifdef PS2_BREAK_DECODE_EN
    if (pe_d || fe_d) begin
      pbrk_d = 1'b0;
      pext_d = 1'b0;
    end
    if (frame_ok) begin
      if (shift_q == PS2_BREAK)    pbrk_d = 1'b1;
      else if (shift_q == PS2_EXT) pext_d = 1'b1;
      else begin
        data_d = shift_q;
        dv_d   = 1'b1;
        brk_d  = pbrk_q;
        ext_d  = pext_q;
        pbrk_d = 1'b0;
        pext_d = 1'b0;
      end
    end
`else
    if (frame_ok) begin
      data_d = shift_q;
      dv_d   = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_prev_q <= 1'b1;
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      data_q   <= 8'h00;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      c_prev_q <= c_filt;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  // Pending prefix qualifiers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pbrk_q <= 1'b0;
      pext_q <= 1'b0;
    end else begin
      pbrk_q <= pbrk_d;
      pext_q <= pext_d;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame. PS/2 timing is scaled down (80-cycle bit period,
// 1000-cycle timeout) so the run stays short; the frame-level model is unaffected.
module tb_ps2_rx_frame;

  localparam int unsigned TMO = 1000;
`ifdef PS2_BREAK_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ps2c, ps2d, rx_en;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, busy, brk, ext;

  ps2_rx_frame #(
    .SYNC_STAGES(2),
    .FILT_LEN   (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .data      (data),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .brk       (brk),
    .ext       (ext)
  );

  always #10 clk = ~clk;

  // Expected event: kind 0 = good byte, 1 = parity error, 2 = frame error
  typedef struct {
    int         kind;
    logic [7:0] b;
    logic       qb;
    logic       qe;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic       pend_brk = 1'b0, pend_ext = 1'b0;
  int         n_tests = 0, n_fail = 0;
  int         cnt_dv = 0, cnt_pe = 0, cnt_fe = 0;
  logic       last_brk = 1'b0, last_ext = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] b, input logic qb, input logic qe);
    ev_t e;
    e.kind = kind; e.b = b; e.qb = qb; e.qe = qe;
    exp_q.push_back(e);
  endtask

  // Frame-level reference: what one complete frame must produce
  task automatic model_frame(input logic [7:0] b, input logic p, input logic s);
    if (!rx_en) return;
    if (!s) begin
      push(2, 8'h00, 1'b0, 1'b0); pend_brk = 1'b0; pend_ext = 1'b0;
    end else if ((($countones(b) + int'(p)) % 2) == 0) begin
      push(1, 8'h00, 1'b0, 1'b0); pend_brk = 1'b0; pend_ext = 1'b0;
    end else if (DEC && b == 8'hF0) begin
      pend_brk = 1'b1;
    end else if (DEC && b == 8'hE0) begin
      pend_ext = 1'b1;
    end else begin
      push(0, b, pend_brk, pend_ext); pend_brk = 1'b0; pend_ext = 1'b0;
    end
  endtask

  function automatic logic oddp(input logic [7:0] b);
    return ~^b;
  endfunction

  // Compare DUT strobes and held data against the model every cycle
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (data_valid) begin cnt_dv++; last_brk = brk; last_ext = ext; end
      if (parity_err) cnt_pe++;
      if (frame_err)  cnt_fe++;
      if (data_valid | parity_err | frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {29'd0, data_valid, parity_err, frame_err},
              (e.kind == 0) ? 32'd4 : (e.kind == 1) ? 32'd2 : 32'd1);
          if (e.kind == 0) begin
            chk("byte", {24'd0, data}, {24'd0, e.b});
            chk("qualifiers", {30'd0, brk, ext}, {30'd0, e.qb, e.qe});
            model_data = e.b;
          end
        end
      end else begin
        chk("idle_qualifiers", {30'd0, brk, ext}, 32'd0);
      end
      chk("data_hold", {24'd0, data}, {24'd0, model_data});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    ps2d = v;
    wait_cyc(20);
    ps2c = 1'b0;
    wait_cyc(40);
    ps2c = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {s, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == 5) chk("busy_mid", {31'd0, busy}, {31'd0, rx_en});
      send_bit(bits[i]);
      if (glitch && i == 3) begin
        // Low pulse one sample short of the filter length
        ps2c = 1'b0;
        wait_cyc(7);
        ps2c = 1'b1;
        wait_cyc(20);
      end
    end
    ps2d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic p, input logic s, input bit glitch);
    model_frame(b, p, s);
    send_frame(b, p, s, 11, glitch);
    wait_cyc(60);
    chk("events_drained", exp_q.size(), 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_data = 8'h00;
    pend_brk = 1'b0;
    pend_ext = 1'b0;
    #1;
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_flags", {26'd0, data_valid, parity_err, frame_err, busy, brk, ext}, 32'd0);
    wait_cyc(5);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(5);
  endtask

  int dv0, pe0, fe0;

  initial begin
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
    wait_cyc(5);
    chk("por_data", {24'd0, data}, 32'd0);
    chk("por_flags", {26'd0, data_valid, parity_err, frame_err, busy, brk, ext}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(10);

    // Good 0x1C
    dv0 = cnt_dv; pe0 = cnt_pe; fe0 = cnt_fe;
    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t1_data", {24'd0, data}, 32'h1C);
    chk("t1_counts", cnt_dv - dv0 + 16 * (cnt_pe - pe0 + cnt_fe - fe0), 32'd1);

    // Parity error keeps previous byte
    dv0 = cnt_dv; pe0 = cnt_pe;
    frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("t2_perr", cnt_pe - pe0, 32'd1);
    chk("t2_nodv", cnt_dv - dv0, 32'd0);
    chk("t2_data", {24'd0, data}, 32'h1C);

    // Stop bit 0 with good parity
    dv0 = cnt_dv; fe0 = cnt_fe; pe0 = cnt_pe;
    frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("t3_ferr", cnt_fe - fe0, 32'd1);
    chk("t3_others", cnt_dv - dv0 + cnt_pe - pe0, 32'd0);

    // Truncated frame abandoned by timeout, then a good one
    fe0 = cnt_fe;
    push(2, 8'h00, 1'b0, 1'b0); pend_brk = 1'b0; pend_ext = 1'b0;
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    wait_cyc(TMO + 300);
    chk("t4_ferr", cnt_fe - fe0, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("t4_data", {24'd0, data}, 32'h5A);

    // Short ps2c glitch mid-frame must not shift a bit
    dv0 = cnt_dv;
    frame(8'h1C, 1'b0, 1'b1, 1'b1);
    chk("t5_data", {24'd0, data}, 32'h1C);
    chk("t5_dv", cnt_dv - dv0, 32'd1);

    // Prefix handling
    dv0 = cnt_dv;
    frame(8'hE0, 1'b0, 1'b1, 1'b0);
    frame(8'hF0, 1'b1, 1'b1, 1'b0);
    frame(8'h75, 1'b0, 1'b1, 1'b0);
    if (DEC) begin
      chk("t6_dv", cnt_dv - dv0, 32'd1);
      chk("t6_data", {24'd0, data}, 32'h75);
      chk("t6_brk_ext", {30'd0, last_brk, last_ext}, 32'd3);
    end else begin
      chk("t6_dv_raw", cnt_dv - dv0, 32'd3);
    end
    frame(8'h75, 1'b0, 1'b1, 1'b0);
    chk("t6_plain", {30'd0, last_brk, last_ext}, 32'd0);

    // Reset in the middle of a frame, then a clean frame
    send_frame(8'h33, 1'b1, 1'b1, 6, 1'b0);
    do_reset();
    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t7_data", {24'd0, data}, 32'h1C);

    // Receiver disabled: whole frame ignored; disable mid-frame drops it silently
    rx_en = 1'b0;
    frame(8'h42, oddp(8'h42), 1'b1, 1'b0);
    rx_en = 1'b1;
    send_frame(8'h42, 1'b1, 1'b1, 4, 1'b0);
    rx_en = 1'b0;
    wait_cyc(2);
    chk("t8_busy", {31'd0, busy}, 32'd0);
    wait_cyc(20);
    rx_en = 1'b1;
    wait_cyc(TMO + 100);
    chk("t8_quiet", exp_q.size(), 32'd0);
    frame(8'h29, oddp(8'h29), 1'b1, 1'b0);

    // Randomised frames
    for (int k = 0; k < 30; k++) begin
      logic [7:0] b;
      logic       p, s;
      int         r;
      r = int'($urandom_range(0, 7));
      b = 8'($urandom);
      if (r == 0) b = 8'hF0;
      if (r == 1) b = 8'hE0;
      p = oddp(b);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 9) != 0);
      frame(b, p, s, ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
